// File: rtl/fsmd_job_arbiter.sv
// Job arbiter for one shared nested-loop sum datapath.
// Round-robin grants a single requester, clears the datapath, streams its
// results back with the requester ID under ready/valid backpressure, and
// ends the job on the datapath done flag or on a watchdog/overflow abort.
//
// state  | meaning
// IDLE   | no job; arbitrate pending requests
// CLEAR  | dp_clr high for this cycle, watchdog and done flag cleared
// RUN    | datapath stepping (when no result is pending), results forwarded
// FINISH | rsp_last pulse, job ended normally
// ABORT  | rsp_err + dp_clr pulse, pending result dropped
module fsmd_job_arbiter #(
    parameter int N_REQ   = 2,
    parameter int DATA_W  = 8,
    parameter int ID_W    = 1,
    parameter int TIMEOUT = 1023
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [N_REQ-1:0]  req,
    output logic [N_REQ-1:0]  grant,
    output logic              dp_clr,
    output logic              dp_run,
    input  logic              dp_new_output,
    input  logic [DATA_W-1:0] dp_out,
    input  logic              dp_done,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ID_W-1:0]   rsp_id,
    output logic              rsp_last,
    output logic              rsp_err
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        RUN    = 3'd2,
        FINISH = 3'd3,
        ABORT  = 3'd4
    } state_t;

    state_t              state_q;
    logic [N_REQ-1:0]    grant_q;
    logic                dp_clr_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic [ID_W-1:0]     rsp_id_q;
    logic                rsp_last_q;
    logic                rsp_err_q;
    logic [ID_W-1:0]     rr_q;
    logic [WD_W-1:0]     wd_q;
    logic                done_q;

    logic [ID_W-1:0]     win_d;
    logic                win_vld_d;
    logic [WD_W-1:0]     wd_d;
    logic                silent_d;
    logic                overflow_d;
    logic                timeout_d;
    logic                finish_d;
    int                  arb_idx;

    // Round-robin pick: first set request after the last winner, with wrap.
    // Iterating from the farthest offset down lets the nearest one win.
    always_comb begin
        win_d     = '0;
        win_vld_d = 1'b0;
        arb_idx   = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            arb_idx = (int'(rr_q) + k) % N_REQ;
            if (req[arb_idx]) begin
                win_d     = ID_W'(arb_idx);
                win_vld_d = 1'b1;
            end
        end
    end

    // RUN-state event decode: watchdog step, overflow, timeout, completion.
    always_comb begin
        silent_d   = ~dp_new_output & ~dp_done;
        wd_d       = wd_q + WD_W'(1);
        overflow_d = dp_new_output & rsp_valid_q;
        timeout_d  = silent_d & (wd_d == WD_W'(TIMEOUT));
        finish_d   = done_q & ~rsp_valid_q;
    end

    // Job sequencer with registered outputs; pulse outputs default low.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            dp_clr_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            rr_q        <= ID_W'(N_REQ - 1);
            wd_q        <= '0;
            done_q      <= 1'b0;
        end else begin
            dp_clr_q   <= 1'b0;
            rsp_last_q <= 1'b0;
            rsp_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_vld_d) begin
                        grant_q  <= N_REQ'(1) << win_d;
                        rsp_id_q <= win_d;
                        rr_q     <= win_d;
                        dp_clr_q <= 1'b1;
                        state_q  <= CLEAR;
                    end
                end
                CLEAR: begin
                    wd_q    <= '0;
                    done_q  <= 1'b0;
                    state_q <= RUN;
                end
                RUN: begin
                    // Overflow wins over completion; a silent timeout loses
                    // to a completion that is ready in the same cycle.
                    if (overflow_d || (timeout_d && !finish_d)) begin
                        rsp_err_q   <= 1'b1;
                        dp_clr_q    <= 1'b1;
                        grant_q     <= '0;
                        rsp_valid_q <= 1'b0;
                        state_q     <= ABORT;
                    end else if (finish_d) begin
                        rsp_last_q <= 1'b1;
                        grant_q    <= '0;
                        state_q    <= FINISH;
                    end else begin
                        if (rsp_valid_q && rsp_ready) begin
                            rsp_valid_q <= 1'b0;
                        end
                        if (dp_new_output) begin
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= dp_out;
                        end
                        if (dp_done) begin
                            done_q <= 1'b1;
                        end
                        wd_q <= silent_d ? wd_d : '0;
                    end
                end
                FINISH:  state_q <= IDLE;
                ABORT:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant     = grant_q;
    assign dp_clr    = dp_clr_q;
    assign dp_run    = (state_q == RUN) & ~rsp_valid_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_last  = rsp_last_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_fsmd_job_arbiter.sv
// Directed bench for fsmd_job_arbiter; the datapath is played by the bench.
module tb_fsmd_job_arbiter;

    localparam int N_REQ   = 2;
    localparam int DATA_W  = 8;
    localparam int ID_W    = 1;
    localparam int TIMEOUT = 16;

    logic              CLK = 1'b0;
    logic              RST;
    logic [N_REQ-1:0]  req;
    logic [N_REQ-1:0]  grant;
    logic              dp_clr;
    logic              dp_run;
    logic              dp_new_output;
    logic [DATA_W-1:0] dp_out;
    logic              dp_done;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [ID_W-1:0]   rsp_id;
    logic              rsp_last;
    logic              rsp_err;

    int n_chk  = 0;
    int n_fail = 0;

    fsmd_job_arbiter #(
        .N_REQ  (N_REQ),
        .DATA_W (DATA_W),
        .ID_W   (ID_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .req          (req),
        .grant        (grant),
        .dp_clr       (dp_clr),
        .dp_run       (dp_run),
        .dp_new_output(dp_new_output),
        .dp_out       (dp_out),
        .dp_done      (dp_done),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_id       (rsp_id),
        .rsp_last     (rsp_last),
        .rsp_err      (rsp_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, 32'(grant), 0);
        chk({tag, "_clr"},   32'(dp_clr), 0);
        chk({tag, "_run"},   32'(dp_run), 0);
        chk({tag, "_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_data"},  32'(rsp_data), 0);
        chk({tag, "_id"},    32'(rsp_id), 0);
        chk({tag, "_last"},  32'(rsp_last), 0);
        chk({tag, "_err"},   32'(rsp_err), 0);
    endtask

    // Raise requests, expect grant in CLEAR, then land in the first RUN cycle.
    task automatic start_job(input logic [1:0] r, input bit hold,
                             input logic [1:0] exp_g, input int exp_id);
        req = r;
        step();
        chk("grant",    32'(grant), 32'(exp_g));
        chk("grant_id", 32'(rsp_id), 32'(exp_id));
        chk("clr_hi",   32'(dp_clr), 1);
        chk("run_clr",  32'(dp_run), 0);
        if (!hold) req = '0;
        step();
        chk("clr_lo",   32'(dp_clr), 0);
        chk("run_hi",   32'(dp_run), 1);
    endtask

    // One result with ready high: visible next cycle, gone the cycle after.
    task automatic emit_ok(input logic [7:0] v, input int exp_id);
        dp_new_output = 1'b1;
        dp_out = v;
        step();
        dp_new_output = 1'b0;
        chk("res_valid", 32'(rsp_valid), 1);
        chk("res_data",  32'(rsp_data), 32'(v));
        chk("res_id",    32'(rsp_id), 32'(exp_id));
        chk("res_run",   32'(dp_run), 0);
        step();
        chk("hs_valid",  32'(rsp_valid), 0);
        chk("hs_run",    32'(dp_run), 1);
    endtask

    task automatic finish_job();
        dp_done = 1'b1;
        step();
        dp_done = 1'b0;
        chk("done_nolast", 32'(rsp_last), 0);
        step();
        chk("last_hi",  32'(rsp_last), 1);
        chk("fin_grant", 32'(grant), 0);
        chk("fin_err",  32'(rsp_err), 0);
        step();
        chk("last_lo",  32'(rsp_last), 0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
    endtask

    initial begin
        logic [7:0] vals [3];
        vals[0] = 8'd3;
        vals[1] = 8'd7;
        vals[2] = 8'd12;

        RST = 1'b1;
        req = '0;
        dp_new_output = 1'b0;
        dp_out = '0;
        dp_done = 1'b0;
        rsp_ready = 1'b1;
        do_reset();
        chk_all_zero("rst");

        // single job, three results then done
        start_job(2'b01, 1'b0, 2'b01, 0);
        for (int i = 0; i < 3; i++) emit_ok(vals[i], 0);
        finish_job();

        // datapath strobes outside RUN are ignored
        dp_new_output = 1'b1;
        dp_done = 1'b1;
        dp_out = 8'h99;
        step();
        dp_new_output = 1'b0;
        dp_done = 1'b0;
        chk("idle_valid", 32'(rsp_valid), 0);
        chk("idle_data",  32'(rsp_data), 32'h0C);
        step();
        chk("idle_grant", 32'(grant), 0);

        // round robin with both requests held
        do_reset();
        start_job(2'b11, 1'b1, 2'b01, 0);
        finish_job();
        start_job(2'b11, 1'b1, 2'b10, 1);
        finish_job();
        start_job(2'b11, 1'b0, 2'b01, 0);
        finish_job();

        // backpressure: five cycles of ready low
        start_job(2'b01, 1'b0, 2'b01, 0);
        rsp_ready = 1'b0;
        dp_new_output = 1'b1;
        dp_out = 8'h55;
        step();
        dp_new_output = 1'b0;
        chk("bp_valid0", 32'(rsp_valid), 1);
        chk("bp_data0",  32'(rsp_data), 32'h55);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", 32'(rsp_valid), 1);
            chk("bp_data",  32'(rsp_data), 32'h55);
            chk("bp_run",   32'(dp_run), 0);
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_release_valid", 32'(rsp_valid), 0);
        chk("bp_release_run",   32'(dp_run), 1);
        emit_ok(8'h66, 0);
        finish_job();

        // last result and done in the same cycle
        start_job(2'b01, 1'b0, 2'b01, 0);
        dp_new_output = 1'b1;
        dp_done = 1'b1;
        dp_out = 8'h2A;
        step();
        dp_new_output = 1'b0;
        dp_done = 1'b0;
        chk("same_valid", 32'(rsp_valid), 1);
        chk("same_data",  32'(rsp_data), 32'h2A);
        chk("same_last0", 32'(rsp_last), 0);
        step();
        chk("same_hs_valid", 32'(rsp_valid), 0);
        chk("same_last1",    32'(rsp_last), 0);
        step();
        chk("same_last2", 32'(rsp_last), 1);
        chk("same_grant", 32'(grant), 0);
        step();
        chk("same_last3", 32'(rsp_last), 0);

        // watchdog: silent datapath, abort on the 17th cycle from RUN entry
        start_job(2'b01, 1'b0, 2'b01, 0);
        for (int i = 1; i <= TIMEOUT - 1; i++) begin
            step();
            chk("to_wait", 32'(rsp_err | rsp_last), 0);
        end
        step();
        chk("to_err",   32'(rsp_err), 1);
        chk("to_clr",   32'(dp_clr), 1);
        chk("to_grant", 32'(grant), 0);
        chk("to_last",  32'(rsp_last), 0);
        chk("to_run",   32'(dp_run), 0);
        step();
        chk("to_err_lo", 32'(rsp_err), 0);
        chk("to_clr_lo", 32'(dp_clr), 0);
        chk("to_last_lo", 32'(rsp_last), 0);

        // overflow: second result while the first is still pending
        start_job(2'b01, 1'b0, 2'b01, 0);
        rsp_ready = 1'b0;
        dp_new_output = 1'b1;
        dp_out = 8'h11;
        step();
        chk("ov_valid0", 32'(rsp_valid), 1);
        dp_out = 8'h22;
        step();
        dp_new_output = 1'b0;
        chk("ov_err",   32'(rsp_err), 1);
        chk("ov_valid", 32'(rsp_valid), 0);
        chk("ov_clr",   32'(dp_clr), 1);
        chk("ov_grant", 32'(grant), 0);
        chk("ov_data",  32'(rsp_data), 32'h11);
        step();
        chk("ov_err_lo", 32'(rsp_err), 0);
        rsp_ready = 1'b1;

        // reset in RUN with a pending result
        start_job(2'b10, 1'b0, 2'b10, 1);
        rsp_ready = 1'b0;
        dp_new_output = 1'b1;
        dp_out = 8'h77;
        step();
        dp_new_output = 1'b0;
        chk("mid_valid", 32'(rsp_valid), 1);
        chk("mid_id",    32'(rsp_id), 1);
        RST = 1'b1;
        step();
        chk_all_zero("midrst");
        RST = 1'b0;
        rsp_ready = 1'b1;
        step();
        chk("post_last",  32'(rsp_last), 0);
        chk("post_err",   32'(rsp_err), 0);
        chk("post_grant", 32'(grant), 0);
        start_job(2'b10, 1'b0, 2'b10, 1);
        finish_job();
        do_reset();
        start_job(2'b11, 1'b0, 2'b01, 0);
        finish_job();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
